multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL provide parameter MEM_WAIT_EN, default 1; 1 = memory states wait for MemReady, 0 = MemReady is ignored and treated as 1.
REQ-002 SHALL provide port CLK  input  1  single system clock; all state changes on the rising edge.
REQ-003 SHALL provide port Reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL provide port Op  input  6  instruction-register opcode field, stable from Decode onward.
REQ-005 SHALL provide port Funct  input  6  instruction-register funct field.
REQ-006 SHALL provide port Zero  input  1  ALU zero flag.
REQ-007 SHALL provide port MemReady  input  1  unified memory completion for the current access.
REQ-008 SHALL provide outputs IorD, IRWrite, MemWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn  output  1 each  datapath controls.
REQ-009 SHALL provide outputs ALUSrcB  output  2  (00 reg B, 01 const 4, 10 SignImm, 11 SignImm<<2) and PCSrc  output  2  (00 ALUResult, 01 ALUOut, 10 jump target).
REQ-010 SHALL provide output ALUControl  output  3  (010 add, 110 sub, 000 and, 001 or, 111 slt).
REQ-011 SHALL provide outputs InstrDone  output  1  one-cycle pulse on the final cycle of each instruction, and IllegalOp  output  1  one-cycle pulse in Decode for an unsupported opcode.

Function
REQ-012 SHALL implement a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
REQ-013 SHALL default every 1-bit output to 0, ALUSrcB/PCSrc to 00, and ALUControl to 010 in any state that does not set them.
REQ-014 FETCH SHALL drive IorD=0, ALUSrcA=0, ALUSrcB=01, ALUControl=010, PCSrc=00, and assert IRWrite and PCEn only in the cycle MemReady=1; it SHALL remain in FETCH while MemReady=0, otherwise go to DECODE.
REQ-015 DECODE SHALL drive ALUSrcA=0, ALUSrcB=11, ALUControl=010, then branch on Op: 100011/101011 -> MEMADR, 000000 -> EXECUTE, 000100 -> BRANCH, 001000 -> ADDIEX, 000010 -> JUMP; any other Op -> FETCH with IllegalOp=1 and InstrDone=1.
REQ-016 MEMADR SHALL drive ALUSrcA=1, ALUSrcB=10, ALUControl=010, then go to MEMREAD for Op=100011, else MEMWRITE.
REQ-017 MEMREAD SHALL drive IorD=1 and hold until MemReady=1, then go to MEMWB.
REQ-018 MEMWB SHALL drive RegDst=0, MemtoReg=1, RegWrite=1, InstrDone=1, then go to FETCH.
REQ-019 MEMWRITE SHALL drive IorD=1 and MemWrite=1 every cycle in the state, and hold until MemReady=1, then go to FETCH with InstrDone=1 in that final cycle.
REQ-020 EXECUTE SHALL drive ALUSrcA=1, ALUSrcB=00, ALUControl from Funct (100000->010, 100010->110, 100100->000, 100101->001, 101010->111), then go to ALUWB; an unlisted Funct SHALL drive 010, assert IllegalOp and InstrDone, and go to FETCH without writeback.
REQ-021 ALUWB SHALL drive RegDst=1, MemtoReg=0, RegWrite=1, InstrDone=1, then go to FETCH.
REQ-022 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, ALUControl=110, PCSrc=01, PCEn=Zero, InstrDone=1, then go to FETCH.
REQ-023 ADDIEX SHALL drive ALUSrcA=1, ALUSrcB=10, ALUControl=010 -> ADDIWB; ADDIWB SHALL drive RegDst=0, MemtoReg=0, RegWrite=1, InstrDone=1 -> FETCH.
REQ-024 JUMP SHALL drive PCSrc=10, PCEn=1, InstrDone=1 -> FETCH.
REQ-025 Latency SHALL be, with MemReady tied 1: lw 5 cycles, sw 4, R-type 4, addi 4, beq 3, j 3; each memory wait cycle SHALL add exactly one cycle.
REQ-026 RegWrite, MemWrite, IRWrite, and PCEn SHALL never be asserted in the same cycle, except IRWrite with PCEn in FETCH.

Reset
REQ-027 While Reset=0, the state SHALL be forced to FETCH asynchronously and all write enables (IRWrite, PCEn, MemWrite, RegWrite) and pulses SHALL be 0 regardless of MemReady.
REQ-028 Reset asserted mid-instruction, including during a memory wait, SHALL abort it with no further writes; after release, the first cycle SHALL be FETCH.

Verification
REQ-029 Reset release, MemReady=1, Op=100011 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 and MemtoReg=1 only in cycle 5; InstrDone pulse in cycle 5.
REQ-030 Op=000000, Funct=101010 -> ALUControl=111 in EXECUTE; RegWrite=1 with RegDst=1 in cycle 4.
REQ-031 Op=000100 with Zero=1 -> PCEn=1 and PCSrc=01 in cycle 3; with Zero=0 -> PCEn=0 in every cycle after FETCH.
REQ-032 Op=101011 with MemReady low for 3 cycles in MEMWRITE -> MemWrite=1 for 4 consecutive cycles; return to FETCH after MemReady=1; total 7 cycles.
REQ-033 Op=111111 -> IllegalOp=1 and InstrDone=1 in DECODE, then FETCH; no RegWrite, MemWrite, or PCEn asserted after the fetch.
REQ-034 Reset driven low during a MEMREAD wait -> FETCH immediately with all enables 0; MEM_WAIT_EN=0 with MemReady=0 -> lw completes in 5 cycles.

Source files
------------

// File: rtl/multicycle_controller.sv
// Control unit for a multicycle MIPS-subset datapath (lw, sw, R-type, beq, addi, j).
// Outputs are a function of the current state, plus MemReady/Zero/Op/Funct where a state samples them.
module multicycle_controller #(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       IorD,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic       PCEn,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic [2:0] ALUControl,
  output logic       InstrDone,
  output logic       IllegalOp
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t state_q, state_d;
  logic   mem_rdy;

  assign mem_rdy = MEM_WAIT_EN ? MemReady : 1'b1;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    IorD       = 1'b0;
    IRWrite    = 1'b0;
    MemWrite   = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    PCEn       = 1'b0;
    ALUSrcB    = 2'b00;
    PCSrc      = 2'b00;
    ALUControl = 3'b010;
    InstrDone  = 1'b0;
    IllegalOp  = 1'b0;

    unique case (state_q)
      FETCH: begin
        ALUSrcB = 2'b01;
        IRWrite = mem_rdy;
        PCEn    = mem_rdy;
        if (mem_rdy) state_d = DECODE;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        case (Op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYP:      state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default: begin
            IllegalOp = 1'b1;
            InstrDone = 1'b1;
            state_d   = FETCH;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (Op == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        IorD = 1'b1;
        if (mem_rdy) state_d = MEMWB;
      end
      MEMWB: begin
        MemtoReg  = 1'b1;
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
        state_d   = FETCH;
      end
      MEMWRITE: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        if (mem_rdy) begin
          InstrDone = 1'b1;
          state_d   = FETCH;
        end
      end
      EXECUTE: begin
        ALUSrcA = 1'b1;
        state_d = ALUWB;
        case (Funct)
          6'b100000: ALUControl = 3'b010;
          6'b100010: ALUControl = 3'b110;
          6'b100100: ALUControl = 3'b000;
          6'b100101: ALUControl = 3'b001;
          6'b101010: ALUControl = 3'b111;
          default: begin
            // Unknown funct: abandon the instruction before any register write.
            IllegalOp = 1'b1;
            InstrDone = 1'b1;
            state_d   = FETCH;
          end
        endcase
      end
      ALUWB: begin
        RegDst    = 1'b1;
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
        state_d   = FETCH;
      end
      BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = 3'b110;
        PCSrc      = 2'b01;
        PCEn       = Zero;
        InstrDone  = 1'b1;
        state_d    = FETCH;
      end
      ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = ADDIWB;
      end
      ADDIWB: begin
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
        state_d   = FETCH;
      end
      JUMP: begin
        PCSrc     = 2'b10;
        PCEn      = 1'b1;
        InstrDone = 1'b1;
        state_d   = FETCH;
      end
      default: state_d = FETCH;
    endcase

    // Held reset must suppress every write and pulse, even though FETCH follows MemReady.
    if (!Reset) begin
      IRWrite   = 1'b0;
      PCEn      = 1'b0;
      MemWrite  = 1'b0;
      RegWrite  = 1'b0;
      InstrDone = 1'b0;
      IllegalOp = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized instruction stream checked cycle by cycle against a step-list model of each instruction.
module tb_multicycle_controller;
  logic CLK = 1'b0;
  logic Reset = 1'b1;
  logic [5:0] Op = 6'b100011;
  logic [5:0] Funct = 6'b100000;
  logic Zero = 1'b0;
  logic MemReady = 1'b1;
  logic IorD, IRWrite, MemWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn, InstrDone, IllegalOp;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUControl;
  // Second instance ignores MemReady and runs lw forever with MemReady held low.
  logic IorD_w, IRWrite_w, MemWrite_w, RegDst_w, MemtoReg_w, RegWrite_w, ALUSrcA_w, PCEn_w;
  logic InstrDone_w, IllegalOp_w;
  logic [1:0] ALUSrcB_w, PCSrc_w;
  logic [2:0] ALUControl_w;

  int total = 0;
  int bad = 0;
  int cyc2 = 0;

  always #5 CLK = ~CLK;

  multicycle_controller #(.MEM_WAIT_EN(1'b1)) dut (
    .CLK(CLK), .Reset(Reset), .Op(Op), .Funct(Funct), .Zero(Zero), .MemReady(MemReady),
    .IorD(IorD), .IRWrite(IRWrite), .MemWrite(MemWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .PCEn(PCEn), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
    .ALUControl(ALUControl), .InstrDone(InstrDone), .IllegalOp(IllegalOp)
  );

  multicycle_controller #(.MEM_WAIT_EN(1'b0)) dut_nowait (
    .CLK(CLK), .Reset(Reset), .Op(6'b100011), .Funct(6'b000000), .Zero(1'b0), .MemReady(1'b0),
    .IorD(IorD_w), .IRWrite(IRWrite_w), .MemWrite(MemWrite_w), .RegDst(RegDst_w),
    .MemtoReg(MemtoReg_w), .RegWrite(RegWrite_w), .ALUSrcA(ALUSrcA_w), .PCEn(PCEn_w),
    .ALUSrcB(ALUSrcB_w), .PCSrc(PCSrc_w), .ALUControl(ALUControl_w),
    .InstrDone(InstrDone_w), .IllegalOp(IllegalOp_w)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [16:0] observed();
    return {IorD, IRWrite, MemWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn,
            ALUSrcB, PCSrc, ALUControl, InstrDone, IllegalOp};
  endfunction

  function automatic bit op_legal(input logic [5:0] op);
    return op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
  endfunction

  function automatic bit funct_legal(input logic [5:0] fn);
    return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] fn);
    if (fn == 6'b100010) return 3'b110;
    if (fn == 6'b100100) return 3'b000;
    if (fn == 6'b100101) return 3'b001;
    if (fn == 6'b101010) return 3'b111;
    return 3'b010;
  endfunction

  function automatic logic [16:0] expect_out(input string st, input bit mr, input bit zr, input bit last);
    logic iord = 0, irw = 0, mw = 0, rdst = 0, m2r = 0, rw = 0, asa = 0, pce = 0, done = 0, ill = 0;
    logic [1:0] asb = 2'b00, pcs = 2'b00;
    logic [2:0] alu = 3'b010;
    if (st == "fetch") begin asb = 2'b01; irw = mr; pce = mr; end
    else if (st == "decode") begin asb = 2'b11; ill = !op_legal(Op); end
    else if (st == "memadr") begin asa = 1; asb = 2'b10; end
    else if (st == "memread") iord = 1;
    else if (st == "memwb") begin m2r = 1; rw = 1; end
    else if (st == "memwrite") begin iord = 1; mw = 1; end
    else if (st == "execute") begin asa = 1; alu = funct_alu(Funct); ill = !funct_legal(Funct); end
    else if (st == "aluwb") begin rdst = 1; rw = 1; end
    else if (st == "branch") begin asa = 1; alu = 3'b110; pcs = 2'b01; pce = zr; end
    else if (st == "addiex") begin asa = 1; asb = 2'b10; end
    else if (st == "addiwb") rw = 1;
    else if (st == "jump") begin pcs = 2'b10; pce = 1; end
    done = last && (st != "memwrite" || mr);
    return {iord, irw, mw, rdst, m2r, rw, asa, pce, asb, pcs, alu, done, ill};
  endfunction

  // mode: 0/1 force MemReady, 2 random
  task automatic step_cycle(input string st, input bit last, input int mode, output bit adv);
    bit mr, zr, ok;
    mr = (mode == 2) ? ($urandom_range(0, 2) != 0) : (mode == 1);
    zr = 1'($urandom_range(0, 1));
    MemReady = mr;
    Zero = zr;
    #2;
    chk({"out_", st}, 32'(observed()), 32'(expect_out(st, mr, zr, last)));
    ok = (32'(RegWrite) + 32'(MemWrite) + 32'(IRWrite) + 32'(PCEn) <= 1) ||
         (IRWrite && PCEn && !RegWrite && !MemWrite);
    chk("wr_excl", 32'(ok), 32'd1);
    chk("nowait_done", 32'(InstrDone_w), 32'(cyc2 % 5 == 4));
    chk("nowait_irw", 32'(IRWrite_w), 32'(cyc2 % 5 == 0));
    adv = !(st == "fetch" || st == "memread" || st == "memwrite") || mr;
    @(posedge CLK);
    #1;
    cyc2++;
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn);
    string steps[$];
    int i, waits;
    bit adv;
    Op = op;
    Funct = fn;
    steps.push_back("fetch");
    steps.push_back("decode");
    if (op == 6'b100011) begin steps.push_back("memadr"); steps.push_back("memread"); steps.push_back("memwb"); end
    else if (op == 6'b101011) begin steps.push_back("memadr"); steps.push_back("memwrite"); end
    else if (op == 6'b000000) begin
      steps.push_back("execute");
      if (funct_legal(fn)) steps.push_back("aluwb");
    end
    else if (op == 6'b000100) steps.push_back("branch");
    else if (op == 6'b001000) begin steps.push_back("addiex"); steps.push_back("addiwb"); end
    else if (op == 6'b000010) steps.push_back("jump");
    i = 0;
    waits = 0;
    while (i < steps.size()) begin
      step_cycle(steps[i], i == steps.size() - 1, (waits >= 6) ? 1 : 2, adv);
      if (adv) begin i++; waits = 0; end
      else waits++;
    end
  endtask

  function automatic logic [5:0] pick_op();
    logic [5:0] ops [10] = '{6'b100011, 6'b101011, 6'b000000, 6'b000000, 6'b000100,
                             6'b001000, 6'b000010, 6'b111111, 6'b001100, 6'b000001};
    return ops[$urandom_range(0, 9)];
  endfunction

  function automatic logic [5:0] pick_funct();
    logic [5:0] fns [7] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
                            6'b000000, 6'b111111};
    return fns[$urandom_range(0, 6)];
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit adv;
    #1 Reset = 1'b0;
    MemReady = 1'b1;
    #10;
    chk("rst_enables", 32'({IRWrite, PCEn, MemWrite, RegWrite, InstrDone, IllegalOp}), 32'd0);
    chk("rst_nowait_en", 32'({IRWrite_w, PCEn_w, RegWrite_w, InstrDone_w}), 32'd0);
    chk("rst_fetch_asb", 32'(ALUSrcB), 32'd1);
    @(posedge CLK);
    #1;
    Reset = 1'b1;
    cyc2 = 0;

    run_instr(6'b100011, 6'b000000);
    run_instr(6'b000000, 6'b101010);
    run_instr(6'b000100, 6'b000000);
    run_instr(6'b101011, 6'b000000);
    run_instr(6'b111111, 6'b000000);
    run_instr(6'b000000, 6'b110011);
    for (int n = 0; n < 300; n++) run_instr(pick_op(), pick_funct());

    // Abort a lw while it waits in MEMREAD.
    Op = 6'b100011;
    step_cycle("fetch", 1'b0, 1, adv);
    step_cycle("decode", 1'b0, 1, adv);
    step_cycle("memadr", 1'b0, 1, adv);
    MemReady = 1'b0;
    #2;
    chk("mr_wait_iord", 32'(IorD), 32'd1);
    #1;
    Reset = 1'b0;
    MemReady = 1'b1;
    #1;
    chk("abort_enables", 32'({IRWrite, PCEn, MemWrite, RegWrite, InstrDone, IllegalOp}), 32'd0);
    chk("abort_fetch", 32'({IorD, ALUSrcB}), 32'b001);
    @(posedge CLK);
    #1;
    chk("abort_hold_en", 32'({IRWrite, PCEn, MemWrite, RegWrite, InstrDone}), 32'd0);
    Reset = 1'b1;
    cyc2 = 0;
    for (int n = 0; n < 20; n++) run_instr(pick_op(), pick_funct());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
